// File: rtl/mod_q_reduce54.sv
// mod_q_reduce54
//   Three-stage elastic pipeline reducing a 54-bit lazily-accumulated
//   coefficient x to x mod q, where q = 549824583172097 = 2^49 - 13125370249215.
//   It uses x = hi*2^49 + lo, so x == lo + T[hi] (mod q). T[k] = k*2^49 mod q
//   is read from an external registered 32-entry table.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_data[53:0]       unreduced value
//   in_tag[TAG_W-1:0]   sideband tag, carried with its coefficient
//   lut_addr[4:0]       table address (combinational)
//   lut_dout[48:0]      table data, registered by the table one cycle after lut_addr
//   out_valid/out_ready output handshake
//   out_data[48:0]      canonical residue in [0, q-1]
//   out_tag             tag of out_data
module mod_q_reduce54 #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [53:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic [4:0]       lut_addr,
  input  logic [48:0]      lut_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [48:0]      out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [48:0] Q = 49'd549824583172097;

  logic             s1_v;
  logic [48:0]      s1_lo;
  logic [4:0]       s1_hi;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_v;
  logic [49:0]      s2_sum;
  logic [TAG_W-1:0] s2_tag;

  logic        out_adv;
  logic        s2_free;
  logic        s1_move;
  logic        s2_move;
  logic        accept;
  logic [49:0] sum_next;
  logic        sum_ge_q;
  logic [48:0] reduced;

  // Each stage may load when it is empty or its content leaves this cycle.
  assign out_adv  = !out_valid || out_ready;
  assign s2_move  = s2_v && out_adv;
  assign s2_free  = !s2_v || out_adv;
  assign s1_move  = s1_v && s2_free;
  assign in_ready = !s1_v || s2_free;
  assign accept   = in_valid && in_ready;

  // The table has no enable: keep re-addressing the held S1 word so that
  // lut_dout still belongs to it after a stall.
  assign lut_addr = accept ? in_data[53:49] : s1_hi;

  // Sum < 2q < 2^50, so 50 bits never overflow.
  assign sum_next = {1'b0, s1_lo} + {1'b0, lut_dout};

  // When sum >= q the true difference is < q < 2^49, so a 49-bit
  // subtraction (modulo 2^49) gives the exact result.
  assign sum_ge_q = s2_sum >= {1'b0, Q};
  assign reduced  = sum_ge_q ? (s2_sum[48:0] - Q) : s2_sum[48:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_lo     <= '0;
      s1_hi     <= '0;
      s1_tag    <= '0;
      s2_v      <= 1'b0;
      s2_sum    <= '0;
      s2_tag    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      if (accept) begin
        s1_v   <= 1'b1;
        s1_lo  <= in_data[48:0];
        s1_hi  <= in_data[53:49];
        s1_tag <= in_tag;
      end else if (s1_move) begin
        s1_v <= 1'b0;
      end

      if (s1_move) begin
        s2_v   <= 1'b1;
        s2_sum <= sum_next;
        s2_tag <= s1_tag;
      end else if (s2_move) begin
        s2_v <= 1'b0;
      end

      if (s2_move) begin
        out_valid <= 1'b1;
        out_data  <= reduced;
        out_tag   <= s2_tag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
